fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 81 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: program-memory port, redirect request and instruction handoff.
// The master modport is the fetch unit; the slave modport is the surrounding core/memory.
interface fetch_unit_if;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       fetch_en;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       halted;

    modport master (
        output rom_addr,
        output instr_valid,
        output instr_data,
        output instr_pc,
        output halted,
        input  rom_data,
        input  fetch_en,
        input  jump_en,
        input  jump_addr,
        input  instr_ready
    );

    modport slave (
        input  rom_addr,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        input  halted,
        output rom_data,
        output fetch_en,
        output jump_en,
        output jump_addr,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a 2-entry {pc, data} buffer, redirect and halt-on-opcode.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    logic [7:0] pc_q, pc_d;
    logic [1:0] count_q, count_d;
    logic       halted_q, halted_d;
    logic [7:0] ent_pc_q   [2];
    logic [7:0] ent_pc_d   [2];
    logic [7:0] ent_data_q [2];
    logic [7:0] ent_data_d [2];

    logic pop;
    logic fetch;

    assign pop   = (count_q != 2'd0) && bus.instr_ready;
    assign fetch = bus.fetch_en && !halted_q && !bus.jump_en && ((count_q != 2'd2) || pop);

    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        halted_d   = halted_q;
        ent_pc_d   = ent_pc_q;
        ent_data_d = ent_data_q;
        if (bus.jump_en) begin
            // Redirect wins over everything; a coinciding pop is simply flushed with the rest.
            pc_d     = bus.jump_addr;
            count_d  = 2'd0;
            halted_d = 1'b0;
        end else begin
            if (pop) begin
                ent_pc_d[0]   = ent_pc_q[1];
                ent_data_d[0] = ent_data_q[1];
                count_d       = count_q - 2'd1;
            end
            if (fetch) begin
                // Tail slot index is the post-pop occupancy (0 or 1).
                ent_pc_d[count_d[0]]   = pc_q;
                ent_data_d[count_d[0]] = bus.rom_data;
                count_d                = count_d + 2'd1;
                if (bus.rom_data == HALT_OPCODE) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            halted_q      <= 1'b0;
            ent_pc_q[0]   <= 8'h00;
            ent_pc_q[1]   <= 8'h00;
            ent_data_q[0] <= 8'h00;
            ent_data_q[1] <= 8'h00;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
            ent_pc_q   <= ent_pc_d;
            ent_data_q <= ent_data_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.instr_data  = ent_data_q[0];
    assign bus.instr_pc    = ent_pc_q[0];
    assign bus.halted      = halted_q;

endmodule
